// File: rtl/dl_deparser_pkg.sv
// Shared types and constants for the Ethernet/VLAN header deparser.
// The DL_DEPARSER_VLAN_EN macro (see dl_deparser.sv) enables the tagged path.
package dl_deparser_pkg;

    localparam int          DATA_W         = 64;
    localparam int          KEEP_W         = DATA_W / 8;
    localparam logic [15:0] TPID_DEFAULT   = 16'h8100;
    localparam int          ETH_HDR_BYTES  = 14;
    localparam int          VLAN_HDR_BYTES = 4;

    // Payload bytes that share a beat with the header tail on each path
    localparam int SFT16_NEW = 2 * KEEP_W - ETH_HDR_BYTES;
    localparam int SFT48_NEW = 3 * KEEP_W - ETH_HDR_BYTES - VLAN_HDR_BYTES;

    typedef enum logic [3:0] {
        IDLE,
        HDR0,
        HDR1,
        SFT16_MORE,
        SFT16_LAST,
        HDR1V,
        HDR2V,
        SFT48_MORE,
        SFT48_LAST
    } state_e;

    function automatic logic [DATA_W-1:0] mask_bytes(input logic [DATA_W-1:0] d,
                                                     input logic [KEEP_W-1:0] s);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < KEEP_W; i++) m[i*8 +: 8] = s[i] ? d[i*8 +: 8] : 8'h00;
        return m;
    endfunction

endpackage

// File: rtl/dl_strb_shift.sv
// Merges a residue of (8-NEW_BYTES) bytes with the top NEW_BYTES of a payload
// beat; also yields the next residue and the strobe of a possible extra beat.
module dl_strb_shift
    import dl_deparser_pkg::*;
#(
    parameter int NEW_BYTES = 2
) (
    input  logic [(KEEP_W-NEW_BYTES)*8-1:0] res_data,
    input  logic [DATA_W-1:0]               in_data,
    input  logic [KEEP_W-1:0]               in_strb,
    output logic [DATA_W-1:0]               mrg_data,
    output logic [KEEP_W-1:0]               mrg_strb,
    output logic [(KEEP_W-NEW_BYTES)*8-1:0] nxt_res,
    output logic [KEEP_W-1:0]               lst_strb,
    output logic                            extra
);
    localparam int RB = KEEP_W - NEW_BYTES;

    assign mrg_data = {res_data, in_data[DATA_W-1 -: NEW_BYTES*8]};
    assign mrg_strb = {{RB{1'b1}}, in_strb[KEEP_W-1 -: NEW_BYTES]};
    assign nxt_res  = in_data[RB*8-1:0];
    assign lst_strb = {in_strb[RB-1:0], {NEW_BYTES{1'b0}}};
    // A byte beyond the merged window is valid: the frame needs one more beat
    assign extra    = in_strb[RB-1];

endmodule

// File: rtl/dl_deparser.sv
// Prepends dst|src|[TPID|tag]|ethtype to a 64-bit payload stream.
// Define DL_DEPARSER_VLAN_EN to build the VLAN-tag insertion path.
module dl_deparser
    import dl_deparser_pkg::*;
#(
    parameter int          C_AXIS_DATA_WIDTH = DATA_W,
    parameter logic [15:0] TPID              = TPID_DEFAULT
) (
    input  logic                           asclk,
    input  logic                           aresetn,
    input  logic                           hdr_valid,
    output logic                           hdr_ready,
    input  logic [47:0]                    dl_dst,
    input  logic [47:0]                    dl_src,
    input  logic [15:0]                    dl_ethtype,
    input  logic [15:0]                    dl_vlantag,
    input  logic                           vlan_en,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   pl_data,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] pl_strb,
    input  logic                           pl_valid,
    input  logic                           pl_last,
    output logic                           pl_ready,
    output logic [C_AXIS_DATA_WIDTH-1:0]   tx_data,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] tx_strb,
    output logic                           tx_valid,
    output logic                           tx_last,
    input  logic                           tx_ready,
    output logic [31:0]                    deparse_cnt,
    output logic [31:0]                    vlan_cnt
);
    state_e              state_q, state_d;
    logic                hdr_ready_q, hdr_ready_d;
    logic                tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [KEEP_W-1:0]   tx_strb_q, tx_strb_d, lst_strb_q, lst_strb_d;
    logic [47:0]         res48_q, res48_d;
    logic [31:0]         deparse_cnt_q, deparse_cnt_d;
    logic                can_load, fin, pl_ready_c;

    logic [DATA_W-1:0]   s16_data;
    logic [KEEP_W-1:0]   s16_strb, s16_lst;
    logic [47:0]         s16_res;
    logic                s16_extra;

    dl_strb_shift #(.NEW_BYTES(SFT16_NEW)) u_sft16 (
        .res_data(res48_q), .in_data(pl_data), .in_strb(pl_strb),
        .mrg_data(s16_data), .mrg_strb(s16_strb), .nxt_res(s16_res),
        .lst_strb(s16_lst), .extra(s16_extra)
    );

`ifdef DL_DEPARSER_VLAN_EN
    logic [15:0]         res16_q, res16_d, tag_q, tag_d;
    logic [31:0]         src_lo_q, src_lo_d, vlan_cnt_q, vlan_cnt_d;
    logic                vlan_q, vlan_d;
    logic [DATA_W-1:0]   s48_data;
    logic [KEEP_W-1:0]   s48_strb, s48_lst;
    logic [15:0]         s48_res;
    logic                s48_extra;

    dl_strb_shift #(.NEW_BYTES(SFT48_NEW)) u_sft48 (
        .res_data(res16_q), .in_data(pl_data), .in_strb(pl_strb),
        .mrg_data(s48_data), .mrg_strb(s48_strb), .nxt_res(s48_res),
        .lst_strb(s48_lst), .extra(s48_extra)
    );
    assign vlan_cnt = vlan_cnt_q;
`else
    logic unused_vlan;
    assign unused_vlan = ^{vlan_en, dl_vlantag, TPID};
    assign vlan_cnt    = 32'd0;
`endif

    always_comb begin
        // A held tx_last beat blocks further loads until it is accepted
        can_load      = (!tx_valid_q || tx_ready) && !(tx_valid_q && tx_last_q);
        fin           = tx_valid_q && tx_ready && tx_last_q;
        state_d       = state_q;
        tx_valid_d    = tx_valid_q && !tx_ready;
        tx_last_d     = tx_last_q;
        tx_data_d     = tx_data_q;
        tx_strb_d     = tx_strb_q;
        res48_d       = res48_q;
        lst_strb_d    = lst_strb_q;
        deparse_cnt_d = deparse_cnt_q;
        pl_ready_c    = 1'b0;
`ifdef DL_DEPARSER_VLAN_EN
        res16_d       = res16_q;
        tag_d         = tag_q;
        src_lo_d      = src_lo_q;
        vlan_d        = vlan_q;
        vlan_cnt_d    = vlan_cnt_q;
`endif
        case (state_q)
            IDLE: if (hdr_valid && hdr_ready_q) begin
                tx_valid_d = 1'b1;
                tx_last_d  = 1'b0;
                tx_data_d  = {dl_dst, dl_src[47:32]};
                tx_strb_d  = '1;
                // Header tail is preloaded as the residue of the first merge
                res48_d    = {dl_src[31:0], dl_ethtype};
                state_d    = HDR1;
`ifdef DL_DEPARSER_VLAN_EN
                res16_d    = dl_ethtype;
                tag_d      = dl_vlantag;
                src_lo_d   = dl_src[31:0];
                vlan_d     = vlan_en;
                if (vlan_en) state_d = HDR1V;
`endif
            end
            HDR1, SFT16_MORE: begin
                pl_ready_c = can_load;
                if (can_load && pl_valid) begin
                    tx_valid_d = 1'b1;
                    res48_d    = s16_res;
                    lst_strb_d = s16_lst;
                    state_d    = (pl_last && s16_extra) ? SFT16_LAST : SFT16_MORE;
                    tx_last_d  = pl_last && !s16_extra;
                    tx_strb_d  = tx_last_d ? s16_strb : '1;
                    tx_data_d  = mask_bytes(s16_data, tx_strb_d);
                end
            end
            SFT16_LAST: if (can_load) begin
                tx_valid_d = 1'b1;
                tx_last_d  = 1'b1;
                tx_strb_d  = lst_strb_q;
                tx_data_d  = mask_bytes({res48_q, 16'h0}, lst_strb_q);
            end
`ifdef DL_DEPARSER_VLAN_EN
            HDR1V: if (can_load) begin
                tx_valid_d = 1'b1;
                tx_data_d  = {src_lo_q, TPID, tag_q};
                tx_strb_d  = '1;
                state_d    = HDR2V;
            end
            HDR2V, SFT48_MORE: begin
                pl_ready_c = can_load;
                if (can_load && pl_valid) begin
                    tx_valid_d = 1'b1;
                    res16_d    = s48_res;
                    lst_strb_d = s48_lst;
                    state_d    = (pl_last && s48_extra) ? SFT48_LAST : SFT48_MORE;
                    tx_last_d  = pl_last && !s48_extra;
                    tx_strb_d  = tx_last_d ? s48_strb : '1;
                    tx_data_d  = mask_bytes(s48_data, tx_strb_d);
                end
            end
            SFT48_LAST: if (can_load) begin
                tx_valid_d = 1'b1;
                tx_last_d  = 1'b1;
                tx_strb_d  = lst_strb_q;
                tx_data_d  = mask_bytes({res16_q, 48'h0}, lst_strb_q);
            end
`endif
            default: ;
        endcase
        if (fin) begin
            state_d       = IDLE;
            tx_last_d     = 1'b0;
            deparse_cnt_d = deparse_cnt_q + 32'd1;
`ifdef DL_DEPARSER_VLAN_EN
            if (vlan_q) vlan_cnt_d = vlan_cnt_q + 32'd1;
`endif
        end
        hdr_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            hdr_ready_q   <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_last_q     <= 1'b0;
            tx_data_q     <= '0;
            tx_strb_q     <= '0;
            res48_q       <= '0;
            lst_strb_q    <= '0;
            deparse_cnt_q <= '0;
`ifdef DL_DEPARSER_VLAN_EN
            res16_q       <= '0;
            tag_q         <= '0;
            src_lo_q      <= '0;
            vlan_q        <= 1'b0;
            vlan_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            hdr_ready_q   <= hdr_ready_d;
            tx_valid_q    <= tx_valid_d;
            tx_last_q     <= tx_last_d;
            tx_data_q     <= tx_data_d;
            tx_strb_q     <= tx_strb_d;
            res48_q       <= res48_d;
            lst_strb_q    <= lst_strb_d;
            deparse_cnt_q <= deparse_cnt_d;
`ifdef DL_DEPARSER_VLAN_EN
            res16_q       <= res16_d;
            tag_q         <= tag_d;
            src_lo_q      <= src_lo_d;
            vlan_q        <= vlan_d;
            vlan_cnt_q    <= vlan_cnt_d;
`endif
        end
    end

    assign hdr_ready   = hdr_ready_q;
    assign pl_ready    = pl_ready_c;
    assign tx_valid    = tx_valid_q;
    assign tx_last     = tx_last_q;
    assign tx_data     = tx_data_q;
    assign tx_strb     = tx_strb_q;
    assign deparse_cnt = deparse_cnt_q;

endmodule
